// File: rtl/result_streamer_pkg.sv
// Shared types and helpers for the result streamer: FSM state encoding and
// the index-width rule used for every word/sample index port.
package result_streamer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd1,
        ST_DONE   = 2'd2
    } state_e;

    // clog2 with a floor of one bit so single-entry configurations keep a real port
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/result_min_tracker.sv
// Running unsigned minimum over the accepted words of one sample; the result is
// published with a one-cycle best_valid pulse after the final beat is accepted.
module result_min_tracker
    import result_streamer_pkg::*;
#(
    parameter int NUM_WEIGHTS = 400,
    parameter int DATA_W      = 32,
    parameter int LANES       = 1
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             clear,
    input  logic                             sample_start,
    input  logic                             beat_fire,
    input  logic                             beat_last,
    input  logic [LANES*DATA_W-1:0]          beat_data,
    input  logic [idx_w(NUM_WEIGHTS)-1:0]    beat_index,
    output logic [idx_w(NUM_WEIGHTS)-1:0]    best_index,
    output logic [DATA_W-1:0]                best_value,
    output logic                             best_valid
);

    localparam int IDX_W = idx_w(NUM_WEIGHTS);
    localparam int EXT_W = IDX_W + 4;

    logic              run_have_q, run_have_d;
    logic [DATA_W-1:0] run_val_q, run_val_d;
    logic [IDX_W-1:0]  run_idx_q, run_idx_d;
    logic [IDX_W-1:0]  best_idx_q, best_idx_d;
    logic [DATA_W-1:0] best_val_q, best_val_d;
    logic              best_vld_q, best_vld_d;

    logic              scan_have;
    logic [DATA_W-1:0] scan_val;
    logic [IDX_W-1:0]  scan_idx;
    logic [EXT_W-1:0]  lane_idx;
    logic [DATA_W-1:0] lane_word;

    // Lanes are scanned low to high with a strict compare, so ties keep the lowest
    // index; padding lanes past the vector end are excluded.
    always_comb begin
        scan_have = run_have_q;
        scan_val  = run_val_q;
        scan_idx  = run_idx_q;
        lane_idx  = '0;
        lane_word = '0;
        for (int l = 0; l < LANES; l++) begin
            lane_idx  = EXT_W'(beat_index) + EXT_W'(l);
            lane_word = beat_data[l*DATA_W +: DATA_W];
            if ((lane_idx < EXT_W'(NUM_WEIGHTS)) && (!scan_have || (lane_word < scan_val))) begin
                scan_have = 1'b1;
                scan_val  = lane_word;
                scan_idx  = IDX_W'(lane_idx);
            end
        end
    end

    always_comb begin
        run_have_d = run_have_q;
        run_val_d  = run_val_q;
        run_idx_d  = run_idx_q;
        best_idx_d = best_idx_q;
        best_val_d = best_val_q;
        best_vld_d = 1'b0;
        if (clear || sample_start) begin
            run_have_d = 1'b0;
            run_val_d  = '0;
            run_idx_d  = '0;
            best_idx_d = '0;
            best_val_d = '0;
        end else if (beat_fire) begin
            run_have_d = scan_have;
            run_val_d  = scan_val;
            run_idx_d  = scan_idx;
            if (beat_last) begin
                best_idx_d = scan_idx;
                best_val_d = scan_val;
                best_vld_d = 1'b1;
                run_have_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_have_q <= 1'b0;
            run_val_q  <= '0;
            run_idx_q  <= '0;
            best_idx_q <= '0;
            best_val_q <= '0;
            best_vld_q <= 1'b0;
        end else begin
            run_have_q <= run_have_d;
            run_val_q  <= run_val_d;
            run_idx_q  <= run_idx_d;
            best_idx_q <= best_idx_d;
            best_val_q <= best_val_d;
            best_vld_q <= best_vld_d;
        end
    end

    assign best_index = best_idx_q;
    assign best_value = best_val_q;
    assign best_valid = best_vld_q;

endmodule

// File: rtl/result_streamer.sv
// Captures a result vector on start and streams it as LANES-wide valid/ready beats,
// one sample at a time, until the job completes. RESULT_MIN_TRACK_EN adds the
// per-sample minimum tracker; without it the best_* outputs are tied to zero.
module result_streamer
    import result_streamer_pkg::*;
#(
    parameter int NUM_WEIGHTS = 400,
    parameter int NUM_SAMPLES = 400,
    parameter int DATA_W      = 32,
    parameter int LANES       = 1
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             start,
    input  logic                             clear,
    input  logic [NUM_WEIGHTS*DATA_W-1:0]    data_in,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [LANES*DATA_W-1:0]          out_data,
    output logic [idx_w(NUM_WEIGHTS)-1:0]    out_index,
    output logic                             out_last,
    output logic [idx_w(NUM_SAMPLES)-1:0]    sample_idx,
    output logic                             busy,
    output logic                             done,
    output logic [idx_w(NUM_WEIGHTS)-1:0]    best_index,
    output logic [DATA_W-1:0]                best_value,
    output logic                             best_valid
);

    localparam int IDX_W  = idx_w(NUM_WEIGHTS);
    localparam int SMP_W  = idx_w(NUM_SAMPLES);
    localparam int VEC_W  = NUM_WEIGHTS * DATA_W;
    localparam int BEAT_W = LANES * DATA_W;
    localparam int PAD_W  = VEC_W + BEAT_W;
    localparam int BASE_W = $clog2(PAD_W);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(((NUM_WEIGHTS - 1) / LANES) * LANES);
    localparam logic [IDX_W-1:0] STEP     = IDX_W'(LANES);
    localparam logic [SMP_W-1:0] LAST_SMP = SMP_W'(NUM_SAMPLES - 1);

    state_e            state_q, state_d;
    logic [VEC_W-1:0]  vec_q, vec_d;
    logic [IDX_W-1:0]  word_cnt_q, word_cnt_d;
    logic [SMP_W-1:0]  sample_q, sample_d;

    logic              stream;
    logic              is_last;
    logic [PAD_W-1:0]  padded;
    logic [BASE_W-1:0] base;

    assign stream  = (state_q == ST_STREAM);
    assign is_last = (word_cnt_q == LAST_IDX);

    // clear has priority over start and over a handshake in the same cycle
    always_comb begin
        state_d    = state_q;
        vec_d      = vec_q;
        word_cnt_d = word_cnt_q;
        sample_d   = sample_q;
        if (clear) begin
            state_d    = ST_IDLE;
            word_cnt_d = '0;
            sample_d   = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        vec_d      = data_in;
                        word_cnt_d = '0;
                        state_d    = ST_STREAM;
                    end
                end
                ST_STREAM: begin
                    if (out_ready) begin
                        if (is_last) begin
                            word_cnt_d = '0;
                            if (sample_q == LAST_SMP) begin
                                state_d = ST_DONE;
                            end else begin
                                sample_d = sample_q + SMP_W'(1);
                                state_d  = ST_IDLE;
                            end
                        end else begin
                            word_cnt_d = word_cnt_q + STEP;
                        end
                    end
                end
                ST_DONE: begin
                    state_d = ST_DONE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            vec_q      <= '0;
            word_cnt_q <= '0;
            sample_q   <= '0;
        end else begin
            state_q    <= state_d;
            vec_q      <= vec_d;
            word_cnt_q <= word_cnt_d;
            sample_q   <= sample_d;
        end
    end

    // Zero words above the vector fill the unused lanes of a short final beat
    assign padded = {{BEAT_W{1'b0}}, vec_q};
    assign base   = BASE_W'(word_cnt_q) * BASE_W'(DATA_W);

    assign out_valid  = stream;
    assign out_data   = stream ? padded[base +: BEAT_W] : '0;
    assign out_index  = stream ? word_cnt_q : '0;
    assign out_last   = stream && is_last;
    assign sample_idx = sample_q;
    assign busy       = stream;
    assign done       = (state_q == ST_DONE);

`ifdef RESULT_MIN_TRACK_EN
    logic take_start;
    logic handshake;

    assign take_start = (state_q == ST_IDLE) && start && !clear;
    assign handshake  = stream && out_ready && !clear;

    result_min_tracker #(
        .NUM_WEIGHTS (NUM_WEIGHTS),
        .DATA_W      (DATA_W),
        .LANES       (LANES)
    ) u_min_tracker (
        .clk          (clk),
        .rst_n        (rst_n),
        .clear        (clear),
        .sample_start (take_start),
        .beat_fire    (handshake),
        .beat_last    (out_last),
        .beat_data    (out_data),
        .beat_index   (out_index),
        .best_index   (best_index),
        .best_value   (best_value),
        .best_valid   (best_valid)
    );
`else
    assign best_index = '0;
    assign best_value = '0;
    assign best_valid = 1'b0;
`endif

endmodule

// File: doc/result_streamer.md
RESULT_STREAMER -- requirements
Module: result_streamer

Interface
REQ-001 SHALL have parameter NUM_WEIGHTS, default 400: 32-bit-equivalent result words per sample vector.
REQ-002 SHALL have parameter NUM_SAMPLES, default 400: sample vectors per job.
REQ-003 SHALL have parameter DATA_W, default 32: bits per result word.
REQ-004 SHALL have parameter LANES, default 1: words emitted per output beat (1..8).
REQ-005 SHALL have port clk, input, 1: clock, rising edge.
REQ-006 SHALL have port rst_n, input, 1: reset, asynchronous, active-low.
REQ-007 SHALL have port start, input, 1: capture data_in and begin streaming one sample.
REQ-008 SHALL have port clear, input, 1: synchronous abort/clear of job.
REQ-009 SHALL have port data_in, input, NUM_WEIGHTS*DATA_W: result vector, word k at bits [k*DATA_W +: DATA_W].
REQ-010 SHALL have port out_valid, output, 1: beat available.
REQ-011 SHALL have port out_ready, input, 1: downstream accepts beat.
REQ-012 SHALL have port out_data, output, LANES*DATA_W: beat payload, lane 0 = lowest word index.
REQ-013 SHALL have port out_index, output, clog2(NUM_WEIGHTS): word index of lane 0.
REQ-014 SHALL have port out_last, output, 1: final beat of current sample.
REQ-015 SHALL have port sample_idx, output, clog2(NUM_SAMPLES): index of sample in flight.
REQ-016 SHALL have port busy, output, 1: high in STREAM.
REQ-017 SHALL have port done, output, 1: job complete, sticky.
REQ-018 SHALL have ports best_index (clog2(NUM_WEIGHTS)), best_value (DATA_W), best_valid (1), outputs: per-sample minimum.

Function
REQ-019 SHALL implement FSM IDLE, STREAM, DONE.
REQ-020 IDLE + start: register data_in, word counter=0, go STREAM; out_valid high the next cycle (latency 1).
REQ-021 STREAM: out_valid high; out_data/out_index/out_last SHALL stay stable while out_valid && !out_ready.
REQ-022 On handshake (out_valid && out_ready) word counter SHALL advance by LANES.
REQ-023 When NUM_WEIGHTS%LANES != 0, unused lanes of final beat SHALL be zero.
REQ-024 Handshake with out_last: if sample_idx==NUM_SAMPLES-1 go DONE, else sample_idx+1 and go IDLE.
REQ-025 DONE: done=1, out_valid=0; start ignored; only clear or reset leave DONE.
REQ-026 start while in STREAM or DONE SHALL be ignored; captured vector unchanged.
REQ-027 clear SHALL override start and handshake in the same cycle: state IDLE, sample_idx=0, counters 0, done=0, out_data=0, best_valid=0.
REQ-028 out_valid SHALL never drop without a handshake except via clear or reset.
REQ-029 NUM_WEIGHTS=1, LANES=1: single beat with out_last=1, out_index=0.

Reset
REQ-030 On rst_n low, asynchronously: state IDLE, out_valid=0, out_data=0, out_index=0, out_last=0, sample_idx=0, busy=0, done=0, best_*=0.
REQ-031 Reset mid-STREAM SHALL drop the beat in flight; no partial resume.

Configuration
REQ-032 Macro RESULT_MIN_TRACK_EN defined: track unsigned minimum over accepted words of current sample; ties keep lowest index; best_valid pulses 1 cycle after the out_last handshake with best_index/best_value held until next start, clear or reset.
REQ-033 Macro undefined: best_index, best_value, best_valid SHALL be tied to 0; no tracker logic.

Structure
REQ-034 Package result_streamer_pkg SHALL hold the state enum and an index-width function.
REQ-035 Minimum tracking SHALL be sub-module result_min_tracker, instantiated only under RESULT_MIN_TRACK_EN.

Verification
REQ-036 NUM_WEIGHTS=4, LANES=1, ready always 1, words 10,20,30,40: beats 10,20,30,40 on consecutive cycles, out_last on 40, sample_idx 0->1.
REQ-037 Same, out_ready low 3 cycles on beat 2: out_data=20, out_index=1 held stable, no beat lost or duplicated.
REQ-038 NUM_WEIGHTS=5, LANES=2: beats {w0,w1},{w2,w3},{w4,0}, out_last on third.
REQ-039 NUM_SAMPLES=2: two start/stream sequences -> done=1 after second out_last; third start ignored; clear -> done=0, sample_idx=0.
REQ-040 clear and start same cycle mid-STREAM: IDLE, out_valid=0 next cycle, no capture.
REQ-041 RESULT_MIN_TRACK_EN, words 7,3,9,3: best_index=1, best_value=3, best_valid one-cycle pulse.
